// File: rtl/motor_pkg.sv
// motor_pkg
//   Shared definitions for the two-motor H-bridge ramp controller:
//   register offsets, channel state encodings, command field positions,
//   the target record carried from the APB decode to each channel, and
//   the clamp/step helpers used by the decode and the channel ramp.
package motor_pkg;

  localparam int DUTY_W  = 10;  // holds 0..PERIOD for PERIOD up to 1023
  localparam int GAP_W   = DUTY_W + 1;
  localparam int DIR_BIT = 16;
  localparam int MAG_MSB = 15;
  localparam int MAG_W   = MAG_MSB + 1;

  localparam logic [7:0] CMD_L  = 8'h00;
  localparam logic [7:0] CMD_R  = 8'h04;
  localparam logic [7:0] STATUS = 8'h08;
  localparam logic [7:0] DUTY_R = 8'h0C;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    BRAKE = 2'd1,
    DEAD  = 2'd2
  } chan_state_e;

  typedef struct packed {
    logic              dir;
    logic [DUTY_W-1:0] mag;
  } target_t;

  // Commanded magnitudes above the PWM period saturate at the period.
  function automatic logic [DUTY_W-1:0] clamp_mag(input logic [MAG_W-1:0] mag,
                                                  input int unsigned       limit);
    if (mag > MAG_W'(limit)) return DUTY_W'(limit);
    return mag[DUTY_W-1:0];
  endfunction

  // Move cur one step toward tgt, landing exactly on tgt when closer than a step.
  function automatic logic [DUTY_W-1:0] step_toward(input logic [DUTY_W-1:0] cur,
                                                    input logic [DUTY_W-1:0] tgt,
                                                    input int unsigned       step);
    logic [GAP_W-1:0] gap;
    if (cur < tgt) begin
      gap = {1'b0, tgt} - {1'b0, cur};
      return (gap <= GAP_W'(step)) ? tgt : cur + DUTY_W'(step);
    end
    if (cur > tgt) begin
      gap = {1'b0, cur} - {1'b0, tgt};
      return (gap <= GAP_W'(step)) ? tgt : cur - DUTY_W'(step);
    end
    return cur;
  endfunction

endpackage

// File: rtl/motor_ramp_chan.sv
// motor_ramp_chan
//   One motor channel: RUN/BRAKE/DEAD sequencer, duty register, dead-time
//   counter and the A/B bridge-input mapping. Duty moves one STEP per tick;
//   a direction change ramps to zero, idles DEADTIME cycles, then flips.
// Ports
//   clk, rst_n    clock, asynchronous active-low reset
//   tick_i        shared ramp tick (one cycle wide)
//   lock_i        forces duty 0 and RUN; dir is preserved
//   target_i      latest commanded direction/magnitude
//   duty_o        current duty magnitude
//   state_o       current sequencer state
//   pw_a_o/pw_b_o bridge duties; at most one is nonzero
module motor_ramp_chan
  import motor_pkg::*;
#(
  parameter int STEP     = 10,
  parameter int DEADTIME = 50000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick_i,
  input  logic              lock_i,
  input  target_t           target_i,
  output logic [DUTY_W-1:0] duty_o,
  output chan_state_e       state_o,
  output logic [31:0]       pw_a_o,
  output logic [31:0]       pw_b_o
);

  localparam int DCW = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;

  chan_state_e       state_q, state_d;
  logic [DUTY_W-1:0] duty_q,  duty_d;
  logic              dir_q,   dir_d;
  logic [DCW-1:0]    dead_q,  dead_d;

  always_comb begin
    // NOTE: every variable gets its hold value first so no path can leave one unassigned (no latch).
    state_d = state_q;
    duty_d  = duty_q;
    dir_d   = dir_q;
    dead_d  = dead_q;
    // Lock takes priority over the tick.
    if (lock_i) begin
      state_d = RUN;
      duty_d  = '0;
      dead_d  = '0;
    end else begin
      unique case (state_q)
        RUN: if (tick_i) begin
          if (target_i.dir != dir_q) state_d = BRAKE;
          else                       duty_d  = step_toward(duty_q, target_i.mag, STEP);
        end
        BRAKE: if (tick_i) begin
          if (duty_q == '0) begin
            state_d = DEAD;
            dead_d  = '0;
          end else begin
            duty_d = step_toward(duty_q, '0, STEP);
          end
        end
        DEAD: begin
          // Counts every cycle, independent of the tick.
          duty_d = '0;
          if (dead_q == DCW'(DEADTIME - 1)) begin
            dir_d   = ~dir_q;
            state_d = RUN;
            dead_d  = '0;
          end else begin
            dead_d = dead_q + 1'b1;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      duty_q  <= '0;
      dir_q   <= 1'b0;
      dead_q  <= '0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      dir_q   <= dir_d;
      dead_q  <= dead_d;
    end
  end

  assign duty_o  = duty_q;
  assign state_o = state_q;
  assign pw_a_o  = dir_q ? '0 : {{(32-DUTY_W){1'b0}}, duty_q};
  assign pw_b_o  = dir_q ? {{(32-DUTY_W){1'b0}}, duty_q} : '0;

endmodule

// File: rtl/motor_ramp_ctrl.sv
// motor_ramp_ctrl
//   APB3 slave ramping the four H-bridge PWM duties of two motors toward
//   software targets, with dead-time on reversal and a sensor-loss lockout.
//   Optional feature macro: MOTOR_CMD_TIMEOUT_EN (command watchdog that zeroes
//   both targets after 2^27 cycles without a CMD write; flagged in STATUS[5]).
// Ports
//   PCLK, PRESERN        clock, asynchronous active-low reset
//   PSEL/PENABLE/PWRITE  APB control; PADDR[7:0] decoded; PWDATA write data
//   PRDATA               registered read data (loaded in the setup cycle)
//   PREADY=1, PSLVERR=0  no wait states, no errors
//   sensor               IR receiver, 1 = beam seen
//   pw1..pw4             left A/B, right A/B duties
//   locked               high during lockout
module motor_ramp_ctrl
  import motor_pkg::*;
#(
  parameter int PERIOD    = 1000,
  parameter int RAMP_DIV  = 10000,
  parameter int STEP      = 10,
  parameter int DEADTIME  = 50000,
  parameter int SENSE_CYC = 20000000,
  parameter int LOCK_CYC  = 500000000
) (
  input  logic        PCLK,
  input  logic        PRESERN,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  input  logic        sensor,
  output logic [31:0] pw1,
  output logic [31:0] pw2,
  output logic [31:0] pw3,
  output logic [31:0] pw4,
  output logic        locked
);

  localparam int TW = (RAMP_DIV  > 1) ? $clog2(RAMP_DIV)  : 1;
  localparam int SW = (SENSE_CYC > 1) ? $clog2(SENSE_CYC) : 1;
  localparam int LW = (LOCK_CYC  > 1) ? $clog2(LOCK_CYC)  : 1;

  logic [TW-1:0]     tick_cnt_q, tick_cnt_d;
  logic [SW-1:0]     sense_cnt_q, sense_cnt_d;
  logic [LW-1:0]     lock_cnt_q, lock_cnt_d;
  logic              locked_q, locked_d;
  target_t           tgt_l_q, tgt_l_d, tgt_r_q, tgt_r_d;
  logic [31:0]       prdata_q, prdata_d, rd_data;
  logic              tick, lock_enter, chan_lock, cmd_wr;
  logic [DUTY_W-1:0] duty_l, duty_r;
  chan_state_e       st_l, st_r;
  logic              wd_flag;
  logic [7:0]        addr;
  logic              unused_bits;

  assign addr        = PADDR[7:0];
  assign unused_bits = ^{PADDR[31:8], PWDATA[31:17]};
  assign tick        = (tick_cnt_q == TW'(RAMP_DIV - 1));
  assign lock_enter  = !locked_q && !sensor && (sense_cnt_q == SW'(SENSE_CYC - 1));
  assign chan_lock   = lock_enter || locked_q;
  assign cmd_wr      = PSEL && PENABLE && PWRITE && !locked_q && (addr == CMD_L || addr == CMD_R);

  // Divider, sensor-loss detector and lockout timer.
  always_comb begin
    tick_cnt_d  = tick ? '0 : tick_cnt_q + 1'b1;
    sense_cnt_d = (locked_q || sensor || lock_enter) ? '0 : sense_cnt_q + 1'b1;
    locked_d    = locked_q;
    lock_cnt_d  = '0;
    if (lock_enter) begin
      locked_d = 1'b1;
    end else if (locked_q) begin
      if (lock_cnt_q == LW'(LOCK_CYC - 1)) locked_d = 1'b0;
      else                                 lock_cnt_d = lock_cnt_q + 1'b1;
    end
  end

`ifdef MOTOR_CMD_TIMEOUT_EN
  logic [26:0] wd_cnt_q, wd_cnt_d;
  logic        wd_to_q, wd_to_d;
  logic        wd_fire;

  assign wd_fire = (wd_cnt_q == '1) && !wd_to_q;
  assign wd_flag = wd_to_q;

  always_comb begin
    wd_cnt_d = (wd_cnt_q == '1) ? wd_cnt_q : wd_cnt_q + 1'b1;
    wd_to_d  = wd_to_q || wd_fire;
    if (cmd_wr) begin
      wd_cnt_d = '0;
      wd_to_d  = 1'b0;
    end
  end

  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      wd_cnt_q <= '0;
      wd_to_q  <= 1'b0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      wd_to_q  <= wd_to_d;
    end
  end
`else
  logic wd_fire;
  assign wd_fire = 1'b0;
  assign wd_flag = 1'b0;
`endif

  // Target registers: lockout entry beats a same-cycle write; a write beats the watchdog.
  always_comb begin
    tgt_l_d = tgt_l_q;
    tgt_r_d = tgt_r_q;
    if (wd_fire) begin
      tgt_l_d = '0;
      tgt_r_d = '0;
    end
    if (cmd_wr) begin
      if (addr == CMD_L) tgt_l_d = '{dir: PWDATA[DIR_BIT], mag: clamp_mag(PWDATA[MAG_MSB:0], PERIOD)};
      else               tgt_r_d = '{dir: PWDATA[DIR_BIT], mag: clamp_mag(PWDATA[MAG_MSB:0], PERIOD)};
    end
    if (lock_enter) begin
      tgt_l_d = '0;
      tgt_r_d = '0;
    end
  end

  always_comb begin
    rd_data = '0;
    unique case (addr)
      STATUS: begin
        rd_data[0]     = locked_q;
        rd_data[2:1]   = st_l;
        rd_data[4:3]   = st_r;
        rd_data[5]     = wd_flag;
        rd_data[25:16] = duty_l;
      end
      DUTY_R:  rd_data[DUTY_W-1:0] = duty_r;
      default: rd_data = '0;
    endcase
    prdata_d = (PSEL && !PENABLE) ? rd_data : prdata_q;
  end

  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      tick_cnt_q  <= '0;
      sense_cnt_q <= '0;
      lock_cnt_q  <= '0;
      locked_q    <= 1'b0;
      tgt_l_q     <= '0;
      tgt_r_q     <= '0;
      prdata_q    <= '0;
    end else begin
      tick_cnt_q  <= tick_cnt_d;
      sense_cnt_q <= sense_cnt_d;
      lock_cnt_q  <= lock_cnt_d;
      locked_q    <= locked_d;
      tgt_l_q     <= tgt_l_d;
      tgt_r_q     <= tgt_r_d;
      prdata_q    <= prdata_d;
    end
  end

  motor_ramp_chan #(.STEP(STEP), .DEADTIME(DEADTIME)) u_chan_l (
    .clk      (PCLK),
    .rst_n    (PRESERN),
    .tick_i   (tick),
    .lock_i   (chan_lock),
    .target_i (tgt_l_q),
    .duty_o   (duty_l),
    .state_o  (st_l),
    .pw_a_o   (pw1),
    .pw_b_o   (pw2)
  );

  motor_ramp_chan #(.STEP(STEP), .DEADTIME(DEADTIME)) u_chan_r (
    .clk      (PCLK),
    .rst_n    (PRESERN),
    .tick_i   (tick),
    .lock_i   (chan_lock),
    .target_i (tgt_r_q),
    .duty_o   (duty_r),
    .state_o  (st_r),
    .pw_a_o   (pw3),
    .pw_b_o   (pw4)
  );

  assign PRDATA  = prdata_q;
  assign PREADY  = 1'b1;
  assign PSLVERR = 1'b0;
  assign locked  = locked_q;

endmodule

// File: tb/tb_motor_ramp_ctrl.sv
// Bench for motor_ramp_ctrl with shortened timing parameters.
module tb_motor_ramp_ctrl;

  localparam logic [7:0] A_CMD_L  = 8'h00;
  localparam logic [7:0] A_CMD_R  = 8'h04;
  localparam logic [7:0] A_STATUS = 8'h08;
  localparam logic [7:0] A_DUTY_R = 8'h0C;
  localparam int         NVEC     = 9;

  logic        PCLK, PRESERN, PSEL, PENABLE, PWRITE, sensor;
  logic [31:0] PADDR, PWDATA, PRDATA, pw1, pw2, pw3, pw4;
  logic        PREADY, PSLVERR, locked;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] exp;
    logic [31:0] mask;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_duty;
  } vec_t;
  vec_t vecs[NVEC];

  motor_ramp_ctrl #(
    .PERIOD(1000), .RAMP_DIV(4), .STEP(10), .DEADTIME(8), .SENSE_CYC(16), .LOCK_CYC(32)
  ) dut (
    .PCLK(PCLK), .PRESERN(PRESERN), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .sensor(sensor), .pw1(pw1), .pw2(pw2), .pw3(pw3), .pw4(pw4), .locked(locked)
  );

  initial begin
    PCLK = 1'b0;
    forever #5 PCLK = ~PCLK;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = {24'h0, a}; PWDATA = d;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  // Expected value is queued at the setup phase and retired when PRDATA is valid.
  task automatic apb_read(input string name, input logic [7:0] a,
                          input logic [31:0] exp, input logic [31:0] mask);
    sb_t e;
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = {24'h0, a};
    e.exp = exp; e.mask = mask;
    sb_q.push_back(e);
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    e = sb_q.pop_front();
    check(name, PRDATA & e.mask, e.exp & e.mask);
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  initial begin
    int steps, bad, cyc, viol, overlap, run, max_run;
    logic [31:0] prev, lo, hi;
    logic done;
    time t_on, t_off;

    vecs[0] = '{A_CMD_L,  32'h0000_0EA6, 32'd1000};
    vecs[1] = '{A_CMD_L,  32'h0000_03E9, 32'd1000};
    vecs[2] = '{A_CMD_L,  32'h0000_FFFF, 32'd1000};
    vecs[3] = '{A_CMD_L,  32'h0000_0005, 32'd5};
    vecs[4] = '{A_CMD_L,  32'h0000_0019, 32'd25};
    vecs[5] = '{8'h10,    32'h0000_03E8, 32'd25};
    vecs[6] = '{A_DUTY_R, 32'h0000_03E8, 32'd25};
    vecs[7] = '{A_CMD_L,  32'h0000_0000, 32'd0};
    vecs[8] = '{A_CMD_L,  32'h0000_0064, 32'd100};

    PRESERN = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0; sensor = 1'b1;
    #12;
    check("reset_pw", pw1 | pw2 | pw3 | pw4, 32'd0);
    check("reset_prdata", PRDATA, 32'd0);
    check("reset_locked", {31'd0, locked}, 32'd0);
    check("const_ready_err", {30'd0, PREADY, PSLVERR}, 32'd2);
    #10 PRESERN = 1'b1;
    apb_read("reset_status", A_STATUS, 32'd0, 32'hFFFF_FFDF);

    // Ramp 0 -> 100 in +10 steps, ten ticks.
    apb_write(A_CMD_L, 32'h0000_0064);
    prev = pw1; steps = 0; bad = 0; cyc = 0; viol = 0; done = 1'b0;
    for (int i = 1; i <= 80 && !done; i++) begin
      @(posedge PCLK); #1;
      if (pw2 != 0) viol++;
      if (pw1 != prev) begin
        steps++;
        if (pw1 != prev + 10) bad++;
        prev = pw1;
      end
      if (pw1 == 32'd100) begin done = 1'b1; cyc = i; end
    end
    check("ramp_reached", {31'd0, done}, 32'd1);
    check("ramp_step_count", steps, 10);
    check("ramp_step_size", bad, 0);
    check("ramp_pw2_zero", viol, 0);
    check("ramp_ten_ticks", {31'd0, (cyc >= 36 && cyc <= 44)}, 32'd1);
    repeat (20) @(posedge PCLK);
    #1 check("ramp_no_overshoot", pw1, 32'd100);

    // Table: settle toward each target, never leaving the [old,new] band.
    for (int v = 0; v < NVEC; v++) begin
      prev = pw1;
      lo = (prev < vecs[v].exp_duty) ? prev : vecs[v].exp_duty;
      hi = (prev > vecs[v].exp_duty) ? prev : vecs[v].exp_duty;
      viol = 0;
      apb_write(vecs[v].addr, vecs[v].wdata);
      repeat (450) begin
        @(posedge PCLK); #1;
        if (pw1 < lo || pw1 > hi || pw2 != 0) viol++;
      end
      check($sformatf("vec%0d_band", v), viol, 0);
      check($sformatf("vec%0d_pw1", v), pw1, vecs[v].exp_duty);
      apb_read($sformatf("vec%0d_status", v), A_STATUS,
               vecs[v].exp_duty << 16, 32'h03FF_0006);
    end

    // Reversal 100 (dir 0) -> 50 (dir 1) through brake and dead-time.
    apb_write(A_CMD_L, 32'h0001_0032);
    prev = pw1; overlap = 0; bad = 0; run = 0; max_run = 0; done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(posedge PCLK); #1;
      if (pw1 != 0 && pw2 != 0) overlap++;
      if (pw1 > prev || pw2 > 50) bad++;
      prev = pw1;
      if (pw1 == 0 && pw2 == 0) begin
        run++;
        if (run > max_run) max_run = run;
      end else run = 0;
      if (pw2 == 32'd50) done = 1'b1;
    end
    check("rev_reached", {31'd0, done}, 32'd1);
    check("rev_overlap", overlap, 0);
    check("rev_monotonic", bad, 0);
    check("rev_deadtime", {31'd0, (max_run >= 8)}, 32'd1);
    check("rev_pw1_zero", pw1, 32'd0);

    // Lockout while right motor runs at 200.
    apb_write(A_CMD_R, 32'h0000_00C8);
    repeat (100) @(posedge PCLK);
    #1 check("lock_pre_pw3", pw3, 32'd200);
    sensor = 1'b0;
    viol = 0;
    repeat (15) begin
      @(posedge PCLK); #1;
      if (locked) viol++;
    end
    check("lock_not_early", viol, 0);
    @(posedge PCLK); #1;
    check("lock_asserted", {31'd0, locked}, 32'd1);
    check("lock_pw_zero", pw1 | pw2 | pw3 | pw4, 32'd0);
    t_on = $time;
    sensor = 1'b1;
    apb_write(A_CMD_R, 32'h0000_0064);
    done = 1'b0;
    t_off = $time;
    for (int i = 0; i < 100 && !done; i++) begin
      @(posedge PCLK); #1;
      if (!locked) begin done = 1'b1; t_off = $time; end
    end
    check("lock_released", {31'd0, done}, 32'd1);
    check("lock_duration", 32'((t_off - t_on) / 10), 32'd32);
    repeat (60) @(posedge PCLK);
    #1 check("lock_pw3_stays0", pw3 | pw4, 32'd0);
    apb_read("lock_duty_r", A_DUTY_R, 32'd0, 32'hFFFF_FFFF);

    // Interrupted sensor loss must not lock.
    viol = 0;
    sensor = 1'b0;
    repeat (15) begin @(posedge PCLK); #1; if (locked) viol++; end
    sensor = 1'b1;
    @(posedge PCLK); #1; if (locked) viol++;
    sensor = 1'b0;
    repeat (15) begin @(posedge PCLK); #1; if (locked) viol++; end
    sensor = 1'b1;
    repeat (3) begin @(posedge PCLK); #1; if (locked) viol++; end
    check("glitch_no_lock", viol, 0);

    // Asynchronous reset in the middle of DEAD.
    apb_write(A_CMD_L, 32'h0001_0064);
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(posedge PCLK); #1;
      if (pw2 == 32'd100) done = 1'b1;
    end
    check("rst_setup_pw2", pw2, 32'd100);
    apb_write(A_CMD_L, 32'h0000_0064);
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(posedge PCLK); #1;
      if (pw2 == 32'd0) done = 1'b1;
    end
    check("rst_brake_done", {31'd0, done}, 32'd1);
    repeat (4) @(posedge PCLK);
    apb_read("rst_in_dead", A_STATUS, 32'h0000_0004, 32'h0000_0006);
    #2 PRESERN = 1'b0;
    #1;
    check("rst_async_prdata", PRDATA, 32'd0);
    check("rst_async_pw", pw1 | pw2 | pw3 | pw4, 32'd0);
    check("rst_async_locked", {31'd0, locked}, 32'd0);
    @(posedge PCLK); #3 PRESERN = 1'b1;
    apb_read("rst_after_status", A_STATUS, 32'd0, 32'hFFFF_FFDF);
    apb_read("rst_after_duty_r", A_DUTY_R, 32'd0, 32'hFFFF_FFFF);
    repeat (20) @(posedge PCLK);
    #1 check("rst_after_pw", pw1 | pw2 | pw3 | pw4, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
